// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory between a decoder write path and a test read path.
// Defining ARB_STATS_EN adds saturating wr_count/rd_count grant counters.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] dec_data,
  output logic              dec_ack,
  input  logic              tst_req,
  input  logic [ADDR_W-1:0] tst_addr,
  output logic [DATA_W-1:0] tst_data,
  output logic              tst_valid,
  output logic              mem_start,
  output logic              mem_rwn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, tdata_q, tdata_d;
  logic rwn_q, rwn_d;
  logic gnt_rd, gnt_wr;
  always_comb begin
    gnt_rd = state_q == IDLE && tst_req && (starve_q == CW'(STARVE_LIMIT) || !dec_req);
    gnt_wr = state_q == IDLE && dec_req && !gnt_rd;
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = gnt_rd ? READ : gnt_wr ? WRITE : IDLE;
      READ:      state_d = READ_WAIT;
      READ_WAIT: state_d = RESP;
      default:   state_d = IDLE;
    endcase
    // the counter only moves while arbitrating; a pending read that is not waiting resets it
    starve_d = state_q != IDLE ? starve_q : (!tst_req || gnt_rd) ? '0 : gnt_wr ? starve_q + CW'(1) : starve_q;
    addr_d   = gnt_rd ? tst_addr : gnt_wr ? dec_addr : addr_q;
    wdata_d  = gnt_wr ? dec_data : wdata_q;
    rwn_d    = gnt_rd ? 1'b1 : gnt_wr ? 1'b0 : rwn_q;
    tdata_d  = state_q == READ_WAIT ? mem_rdata : tdata_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tdata_q  <= '0;
      rwn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tdata_q  <= tdata_d;
      rwn_q    <= rwn_d;
    end
  end
  assign mem_start = state_q == WRITE || state_q == READ;
  assign mem_rwn   = rwn_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dec_ack   = state_q == WRITE;
  assign tst_valid = state_q == RESP;
  assign tst_data  = tdata_q;
  assign busy      = state_q != IDLE;
`ifdef ARB_STATS_EN
  logic [15:0] wr_q, rd_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (gnt_wr && wr_q != 16'hFFFF) wr_q <= wr_q + 16'd1;
      if (gnt_rd && rd_q != 16'hFFFF) rd_q <= rd_q + 16'd1;
    end
  end
  assign wr_count = wr_q;
  assign rd_count = rd_q;
`endif
endmodule
